popcount_range: RTL and testbench
=================================

# popcount_range

Streaming, parametrised population-count range detector. Accepts one WIDTH-bit word per valid/ready transfer and computes its popcount. Flags the word when the popcount lies within a runtime window [lo, hi]. Keeps a saturating count of matched words. It generalises the fixed 4-input "two or three bits set" detector to any width and any window, and adds a two-stage pipeline with backpressure so it can sit directly on a data stream between producer and consumer blocks.

## Interface
Parameters:
- WIDTH, 16, data word width (≥ 2)
- CNT_W, 16, width of the match counter
- PC_W, $clog2(WIDTH+1), popcount width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- nrst  in  1  reset, asynchronous and active-low
- in_valid  in  1  input word present
- in_ready  out  1  block can accept input this cycle
- in_data  in  WIDTH  input word
- lo  in  PC_W  window lower bound (inclusive), sampled with the word
- hi  in  PC_W  window upper bound (inclusive), sampled with the word
- clear  in  1  synchronous clear of match_cnt
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_match  out  1  lo ≤ popcount ≤ hi for this word
- out_pc  out  PC_W  popcount of this word
- match_cnt  out  CNT_W  number of matched results transferred since reset/clear

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Stage 1 (S1) registers the popcount of in_data, plus lo and hi as presented in the same cycle. Later changes to lo/hi never affect words already accepted.
- Stage 2 (S2) registers out_pc and out_match = (lo_s1 ≤ pc_s1) && (pc_s1 ≤ hi_s1), using unsigned compare.
- lo > hi: out_match = 0 for every word.
- hi ≥ WIDTH with lo = 0: every word matches.
- Pipeline advance rules:
  - S2 loads when it is empty or its output transfer occurs.
  - S1 loads when it is empty or S1 moves into S2.
  - in_ready = !s1_valid || s1_moves. This is combinational from registered state and out_ready; there is no combinational path from in_valid.
- Holding: out_valid, out_match and out_pc remain stable while out_valid && !out_ready.
- match_cnt increments by 1 on each output transfer with out_match = 1. It saturates at 2^CNT_W − 1.
- clear: match_cnt becomes 0 next cycle. If clear coincides with an increment, clear wins (result 0). clear never disturbs pipeline contents.
- Reset (nrst low, at any time, including mid-stream): all valids are 0, out_match = 0, out_pc = 0, match_cnt = 0. In-flight words are discarded. in_ready reads 1 because the pipeline is empty.

## Timing
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N+1 when there is no backpressure (2 register stages).
- Throughput: 1 word/cycle with out_ready held high.
- Backpressure: with out_ready low, the pipeline absorbs 2 words and then in_ready falls. When out_ready rises, in_ready rises in the same cycle.
- match_cnt reflects a transfer on the edge that completes that transfer.
- Deassertion of nrst is synchronised externally. The block is not required to tolerate deassertion near a clock edge.

## Structure
- Package popcount_pkg holds:
  - function pc_width(int w)
  - a parametrised popcount function usable in both RTL and bench reference models
  - typedef for the S1 payload struct (pc, lo, hi)
- Sub-module popcount_tree (parameter WIDTH): combinational balanced adder tree, in_data → PC_W sum. It is instantiated once, in front of S1.
- Top level holds the two stage registers, the handshake logic and the counter.

## Test plan
- WIDTH=4, lo=2, hi=3, sweep in_data 0x0–0xF with out_ready=1. Required response:
  - out_match = 1 exactly for 3,5,6,7,9,A,B,C,D,E
  - out_match = 0 for 0,1,2,4,8,F
  - match_cnt = 10 at the end
  - each result arrives 2 cycles after its input
- WIDTH=16, lo=5, hi=2, random words → out_match always 0, match_cnt stays 0.
- Change lo/hi every cycle while streaming → each out_match uses the bounds present on that word's input transfer (check against the scoreboard).
- Hold out_ready=0 for 5 cycles while in_valid=1 → exactly 2 words accepted, in_ready=0 from the third cycle, outputs stable. Release → in-order delivery with no loss or duplication.
- CNT_W=3, send 9 matching words → match_cnt reads 7 and holds. Assert clear in the same cycle as a matching transfer → match_cnt = 0.
- Pull nrst low with 2 words in flight → out_valid=0, match_cnt=0 immediately (asynchronously). Release reset → next word produces a correct result with 2-cycle latency.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount range detector: width helper, a
// reference popcount and the stage-1 payload record.
package popcount_pkg;

    localparam int MAX_W = 256;

    function automatic int pc_width(int w);
        return $clog2(w + 1);
    endfunction

    localparam int PC_MAX_W = pc_width(MAX_W);

    // Callers zero-extend narrower words to MAX_W; padding bits count as zero.
    function automatic int popcount(logic [MAX_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [PC_MAX_W-1:0] lo;
        logic [PC_MAX_W-1:0] hi;
    } s1_payload_t;

endpackage

// File: rtl/popcount_tree.sv
// Combinational balanced adder tree producing the number of set bits in a word.
module popcount_tree
    import popcount_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int PC_W = pc_width(WIDTH)
) (
    input  logic [WIDTH-1:0] in_data,
    output logic [PC_W-1:0]  sum
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int N      = 1 << LEVELS;

    logic [N-1:0] padded;

    assign padded = N'(in_data);

    // Pairwise in-place reduction: each pass halves the live node count.
    always_comb begin : p_tree
        logic [PC_W-1:0] node [N];
        for (int i = 0; i < N; i++) begin
            node[i] = PC_W'(padded[i]);
        end
        for (int span = 1; span < N; span = span * 2) begin
            for (int i = 0; i < N; i = i + 2 * span) begin
                node[i] = node[i] + node[i + span];
            end
        end
        sum = node[0];
    end

endmodule

// File: rtl/popcount_range.sv
// Two-stage streaming popcount window detector with valid/ready handshake
// on both sides and a saturating count of matched results.
module popcount_range
    import popcount_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16,
    localparam int PC_W = pc_width(WIDTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [PC_W-1:0]  lo,
    input  logic [PC_W-1:0]  hi,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_match,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] match_cnt
);

    logic [PC_W-1:0] pc_p0;

    s1_payload_t     pay_p1_q, pay_p1_d;
    logic            vld_p1_q, vld_p1_d;
    logic            vld_p2_q, vld_p2_d;
    logic            match_p2_q, match_p2_d;
    logic [PC_W-1:0] pc_p2_q, pc_p2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic out_xfer;
    logic s2_load;
    logic s1_move;
    logic in_xfer;

    popcount_tree #(.WIDTH(WIDTH)) u_tree (
        .in_data (in_data),
        .sum     (pc_p0)
    );

    always_comb begin
        out_xfer = vld_p2_q && out_ready;
        s2_load  = !vld_p2_q || out_xfer;
        s1_move  = vld_p1_q && s2_load;
        in_ready = !vld_p1_q || s1_move;
        in_xfer  = in_valid && in_ready;
    end

    // Stage 0 -> 1: capture popcount with the bounds presented alongside it.
    always_comb begin
        vld_p1_d = in_ready ? in_valid : vld_p1_q;
        pay_p1_d = pay_p1_q;
        if (in_xfer) begin
            pay_p1_d.pc = PC_MAX_W'(pc_p0);
            pay_p1_d.lo = PC_MAX_W'(lo);
            pay_p1_d.hi = PC_MAX_W'(hi);
        end
    end

    // Stage 1 -> 2: window compare; lo > hi naturally yields no match.
    always_comb begin
        vld_p2_d   = s2_load ? vld_p1_q : vld_p2_q;
        pc_p2_d    = pc_p2_q;
        match_p2_d = match_p2_q;
        if (s1_move) begin
            pc_p2_d    = PC_W'(pay_p1_q.pc);
            match_p2_d = (pay_p1_q.lo <= pay_p1_q.pc) && (pay_p1_q.pc <= pay_p1_q.hi);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (out_xfer && match_p2_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            match_p2_q <= 1'b0;
            pc_p2_q    <= '0;
            cnt_q      <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            match_p2_q <= match_p2_d;
            pc_p2_q    <= pc_p2_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        pay_p1_q <= pay_p1_d;
    end

    assign out_valid = vld_p2_q;
    assign out_match = match_p2_q;
    assign out_pc    = pc_p2_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_popcount_range.sv
// Bench for popcount_range: a WIDTH=4 instance and a WIDTH=16/CNT_W=3 instance,
// each with a queue-based scoreboard checked on every output transfer.
module tb_popcount_range;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // WIDTH=4, CNT_W=16 instance
    logic       iv4 = 0, ir4, cl4 = 0, ov4, or4 = 1, om4;
    logic [3:0] id4 = 0;
    logic [2:0] lo4 = 0, hi4 = 0, opc4;
    logic [15:0] mc4;

    // WIDTH=16, CNT_W=3 instance
    logic        iv16 = 0, ir16, cl16 = 0, ov16, or16 = 1, om16;
    logic [15:0] id16 = 0;
    logic [4:0]  lo16 = 0, hi16 = 0, opc16;
    logic [2:0]  mc16;

    popcount_range #(.WIDTH(4), .CNT_W(16)) dut4 (
        .clk(clk), .nrst(nrst), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .lo(lo4), .hi(hi4), .clear(cl4), .out_valid(ov4), .out_ready(or4),
        .out_match(om4), .out_pc(opc4), .match_cnt(mc4)
    );

    popcount_range #(.WIDTH(16), .CNT_W(3)) dut16 (
        .clk(clk), .nrst(nrst), .in_valid(iv16), .in_ready(ir16), .in_data(id16),
        .lo(lo16), .hi(hi16), .clear(cl16), .out_valid(ov16), .out_ready(or16),
        .out_match(om16), .out_pc(opc16), .match_cnt(mc16)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic       m;
        logic [7:0] pc;
        int         cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q16[$];
    int   exp_cnt4 = 0;
    int   exp_cnt16 = 0;
    bit   chk_lat4 = 0;

    logic       hv4 = 0, hm4 = 0;
    logic [2:0] hpc4 = 0;

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!nrst) begin
            q4.delete();
            exp_cnt4 = 0;
            hv4 = 0;
        end else begin
            chk("cnt4", 32'(mc4), 32'(exp_cnt4));
            if (hv4) begin
                chk("hold_valid4", 32'(ov4), 32'(1));
                chk("hold_match4", 32'(om4), 32'(hm4));
                chk("hold_pc4", 32'(opc4), 32'(hpc4));
            end
            if (ov4 && or4) begin
                if (q4.size() == 0) begin
                    chk("extra_out4", 32'(1), 32'(0));
                end else begin
                    e = q4.pop_front();
                    chk("match4", 32'(om4), 32'(e.m));
                    chk("pc4", 32'(opc4), 32'(e.pc));
                    if (chk_lat4) chk("latency4", 32'(cyc - e.cyc), 32'(2));
                    if (e.m && exp_cnt4 != 65535) exp_cnt4++;
                end
            end
            if (cl4) exp_cnt4 = 0;
            hv4 = ov4 && !or4;
            hm4 = om4;
            hpc4 = opc4;
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (!nrst) begin
            q16.delete();
            exp_cnt16 = 0;
        end else begin
            chk("cnt16", 32'(mc16), 32'(exp_cnt16));
            if (ov16 && or16) begin
                if (q16.size() == 0) begin
                    chk("extra_out16", 32'(1), 32'(0));
                end else begin
                    e = q16.pop_front();
                    chk("match16", 32'(om16), 32'(e.m));
                    chk("pc16", 32'(opc16), 32'(e.pc));
                    if (e.m && exp_cnt16 != 7) exp_cnt16++;
                end
            end
            if (cl16) exp_cnt16 = 0;
        end
    end

    task automatic send4(input logic [3:0] d, input logic [2:0] l, input logic [2:0] h,
                         input logic em, input logic [2:0] epc);
        int n;
        exp_t e;
        iv4 = 1; id4 = d; lo4 = l; hi4 = h;
        n = 0;
        @(negedge clk);
        while (!ir4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ir4) begin
            chk("send4_timeout", 32'(0), 32'(1));
        end else begin
            e.m = em; e.pc = 8'(epc); e.cyc = cyc;
            q4.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic send16(input logic [15:0] d, input logic [4:0] l, input logic [4:0] h);
        int n, pc;
        exp_t e;
        pc = $countones(d);
        iv16 = 1; id16 = d; lo16 = l; hi16 = h;
        n = 0;
        @(negedge clk);
        while (!ir16 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ir16) begin
            chk("send16_timeout", 32'(0), 32'(1));
        end else begin
            e.m = (int'(l) <= pc) && (pc <= int'(h));
            e.pc = 8'(pc); e.cyc = cyc;
            q16.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        iv4 = 0; iv16 = 0;
        n = 0;
        while ((q4.size() != 0 || q16.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 32'(q4.size() + q16.size()), 32'(0));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [3:0] d;
        logic [2:0] lo;
        logic [2:0] hi;
        logic       m;
        logic [2:0] pc;
    } vec_t;

    vec_t tbl[20];
    logic [3:0] bp_d[5];
    logic       bp_m[5];
    logic       bp_rdy[5];
    logic       bp_ov[5];

    initial begin
        // in_data, lo, hi, expected match, expected popcount
        tbl[0]  = '{4'h0, 3'd2, 3'd3, 1'b0, 3'd0};
        tbl[1]  = '{4'h1, 3'd2, 3'd3, 1'b0, 3'd1};
        tbl[2]  = '{4'h2, 3'd2, 3'd3, 1'b0, 3'd1};
        tbl[3]  = '{4'h3, 3'd2, 3'd3, 1'b1, 3'd2};
        tbl[4]  = '{4'h4, 3'd2, 3'd3, 1'b0, 3'd1};
        tbl[5]  = '{4'h5, 3'd2, 3'd3, 1'b1, 3'd2};
        tbl[6]  = '{4'h6, 3'd2, 3'd3, 1'b1, 3'd2};
        tbl[7]  = '{4'h7, 3'd2, 3'd3, 1'b1, 3'd3};
        tbl[8]  = '{4'h8, 3'd2, 3'd3, 1'b0, 3'd1};
        tbl[9]  = '{4'h9, 3'd2, 3'd3, 1'b1, 3'd2};
        tbl[10] = '{4'hA, 3'd2, 3'd3, 1'b1, 3'd2};
        tbl[11] = '{4'hB, 3'd2, 3'd3, 1'b1, 3'd3};
        tbl[12] = '{4'hC, 3'd2, 3'd3, 1'b1, 3'd2};
        tbl[13] = '{4'hD, 3'd2, 3'd3, 1'b1, 3'd3};
        tbl[14] = '{4'hE, 3'd2, 3'd3, 1'b1, 3'd3};
        tbl[15] = '{4'hF, 3'd2, 3'd3, 1'b0, 3'd4};
        tbl[16] = '{4'hF, 3'd0, 3'd7, 1'b1, 3'd4};
        tbl[17] = '{4'h0, 3'd0, 3'd4, 1'b1, 3'd0};
        tbl[18] = '{4'h7, 3'd3, 3'd1, 1'b0, 3'd3};
        tbl[19] = '{4'hF, 3'd4, 3'd4, 1'b1, 3'd4};

        bp_d[0] = 4'h1; bp_m[0] = 1'b0; bp_rdy[0] = 1'b1; bp_ov[0] = 1'b0;
        bp_d[1] = 4'h3; bp_m[1] = 1'b1; bp_rdy[1] = 1'b1; bp_ov[1] = 1'b0;
        bp_d[2] = 4'h7; bp_m[2] = 1'b1; bp_rdy[2] = 1'b0; bp_ov[2] = 1'b1;
        bp_d[3] = 4'h7; bp_m[3] = 1'b1; bp_rdy[3] = 1'b0; bp_ov[3] = 1'b1;
        bp_d[4] = 4'h7; bp_m[4] = 1'b1; bp_rdy[4] = 1'b0; bp_ov[4] = 1'b1;

        #2;
        chk("rst_in_ready4", 32'(ir4), 32'(1));
        chk("rst_out_valid4", 32'(ov4), 32'(0));
        chk("rst_out_match4", 32'(om4), 32'(0));
        chk("rst_out_pc4", 32'(opc4), 32'(0));
        chk("rst_cnt4", 32'(mc4), 32'(0));
        chk("rst_out_valid16", 32'(ov16), 32'(0));
        chk("rst_cnt16", 32'(mc16), 32'(0));
        #10 nrst = 1;
        @(posedge clk); #1;

        // WIDTH=4 sweep with lo=2, hi=3, then window boundary vectors
        chk_lat4 = 1;
        for (int i = 0; i < 16; i++) send4(tbl[i].d, tbl[i].lo, tbl[i].hi, tbl[i].m, tbl[i].pc);
        drain();
        chk("sweep_cnt4", 32'(mc4), 32'(10));
        for (int i = 16; i < 20; i++) send4(tbl[i].d, tbl[i].lo, tbl[i].hi, tbl[i].m, tbl[i].pc);
        drain();
        chk("window_cnt4", 32'(mc4), 32'(13));
        chk_lat4 = 0;

        // Backpressure: two words absorbed, third held until out_ready returns
        begin
            int idx;
            exp_t e;
            or4 = 0; iv4 = 1; lo4 = 3'd2; hi4 = 3'd3;
            idx = 0;
            for (int k = 0; k < 5; k++) begin
                id4 = bp_d[idx];
                @(negedge clk);
                chk("bp_in_ready4", 32'(ir4), 32'(bp_rdy[k]));
                chk("bp_out_valid4", 32'(ov4), 32'(bp_ov[k]));
                if (ir4) begin
                    e.m = bp_m[idx]; e.pc = 8'($countones(bp_d[idx])); e.cyc = cyc;
                    q4.push_back(e);
                    idx++;
                end
                @(posedge clk); #1;
            end
            chk("bp_accepted4", 32'(idx), 32'(2));
            or4 = 1;
            id4 = bp_d[idx];
            @(negedge clk);
            chk("bp_release_ready4", 32'(ir4), 32'(1));
            if (ir4) begin
                e.m = bp_m[idx]; e.pc = 8'($countones(bp_d[idx])); e.cyc = cyc;
                q4.push_back(e);
            end
            @(posedge clk); #1;
            drain();
            chk("bp_cnt4", 32'(mc4), 32'(15));
        end

        // WIDTH=16: empty window (lo > hi)
        for (int i = 0; i < 20; i++) send16(16'($urandom), 5'd5, 5'd2);
        drain();
        chk("empty_window_cnt16", 32'(mc16), 32'(0));

        // WIDTH=16: bounds change on every word
        for (int i = 0; i < 40; i++) begin
            send16(16'($urandom), 5'($urandom_range(0, 20)), 5'($urandom_range(0, 20)));
        end
        drain();

        // CNT_W=3 saturation and clear priority
        cl16 = 1; @(posedge clk); #1; cl16 = 0;
        chk("clear_cnt16", 32'(mc16), 32'(0));
        for (int i = 0; i < 9; i++) send16(16'($urandom), 5'd0, 5'd16);
        drain();
        chk("sat_cnt16", 32'(mc16), 32'(7));
        send16(16'hFFFF, 5'd0, 5'd16);
        drain();
        chk("sat_hold_cnt16", 32'(mc16), 32'(7));
        cl16 = 1; @(posedge clk); #1; cl16 = 0;
        send16(16'h00FF, 5'd8, 5'd8);
        drain();
        chk("one_cnt16", 32'(mc16), 32'(1));
        send16(16'h0F0F, 5'd8, 5'd8);
        iv16 = 0;
        @(posedge clk); #1;
        chk("clr_xfer_valid16", 32'(ov16), 32'(1));
        cl16 = 1;
        @(posedge clk); #1;
        cl16 = 0;
        chk("clr_wins_cnt16", 32'(mc16), 32'(0));
        chk("clr_q16_empty", 32'(q16.size()), 32'(0));

        // Asynchronous reset with two words in flight
        or4 = 0;
        send4(4'h3, 3'd2, 3'd3, 1'b1, 3'd2);
        send4(4'h5, 3'd2, 3'd3, 1'b1, 3'd2);
        iv4 = 0;
        #2 nrst = 0;
        #1;
        chk("async_rst_valid4", 32'(ov4), 32'(0));
        chk("async_rst_cnt4", 32'(mc4), 32'(0));
        chk("async_rst_match4", 32'(om4), 32'(0));
        chk("async_rst_pc4", 32'(opc4), 32'(0));
        chk("async_rst_ready4", 32'(ir4), 32'(1));
        @(negedge clk);
        @(posedge clk);
        #2 nrst = 1;
        or4 = 1;
        chk_lat4 = 1;
        send4(4'hB, 3'd2, 3'd3, 1'b1, 3'd3);
        drain();
        chk("post_rst_cnt4", 32'(mc4), 32'(1));

        chk("final_q4", 32'(q4.size()), 32'(0));
        chk("final_q16", 32'(q16.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end

endmodule
